// File: rtl/div_iter_param.sv
// Iterative restoring divider (signed/unsigned) producing {remainder,quotient}, one bit per cycle.
// Optional build macro DIV_EARLY_OUT_EN: skip the iteration when |divisor| > |dividend|.
module div_iter_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_dvd;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_zero;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_dz;

  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic               w_early;
  logic [WIDTH:0]     w_part;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;

  function automatic logic [WIDTH-1:0] f_cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign w_neg1  = signed_div_i & opdata1_i[WIDTH-1];
  assign w_neg2  = signed_div_i & opdata2_i[WIDTH-1];
  assign w_abs1  = f_cond_neg(w_neg1, opdata1_i);
  assign w_abs2  = f_cond_neg(w_neg2, opdata2_i);
  assign w_early = (opdata2_i != '0) && (w_abs2 > w_abs1);

  // Restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  assign w_part    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_part >= {1'b0, r_div});
  assign w_rem_nxt = w_ge ? (w_part[WIDTH-1:0] - r_div) : w_part[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_dz     <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_dvd    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
    end else if (annul_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_rem   <= '0;
            r_quo   <= w_abs1;
            r_div   <= w_abs2;
            r_dvd   <= opdata1_i;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
            r_zero  <= (opdata2_i == '0);
            r_cnt   <= '0;
            if (opdata2_i == '0) begin
              r_state <= S_DIVZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (w_early) begin
              r_state <= S_DIVZERO;
`endif
            end else begin
              r_state <= S_ON;
            end
          end
        end
        // Shared one-cycle path for divide-by-zero and early termination.
        S_DIVZERO: begin
          r_result <= r_zero ? '0 : {r_dvd, {WIDTH{1'b0}}};
          r_dz     <= r_zero;
          r_ready  <= 1'b1;
          r_state  <= S_END;
        end
        S_ON: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_result <= {f_cond_neg(r_neg_r, w_rem_nxt), f_cond_neg(r_neg_q, w_quo_nxt)};
            r_dz     <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= S_END;
          end
        end
        default: begin
          if (!start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_dz     <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  logic w_unused;
  assign w_unused = w_early;

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign busy_o     = (r_state != S_IDLE);
  assign div_zero_o = r_dz;

endmodule
